// File: rtl/maxpool_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_pkg
//  Purpose  : Shared FSM state encoding, default geometry constants and small
//             helpers for the 2x2 max-pooling controller.
//  Options  : MAXPOOL_RELU_EN (used by max_acc) clamps pooled values at zero.
//  Revision : 1.0  initial release
// ============================================================================
package maxpool_pkg;

    // Default geometry of the convolution map and memory interface
    localparam int MP_N_C    = 26;
    localparam int MP_N_R    = 26;
    localparam int MP_DATA_W = 8;
    localparam int MP_ADDR_W = 10;

    // Controller states: four reads, one cycle to absorb the last datum,
    // one write cycle, and a one-cycle end-of-frame marker
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_ACC  = 3'd5,
        ST_WR   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    // True for the states that issue a conv-memory read
    function automatic logic is_read_state(input state_t s);
        return (s == ST_RD0) || (s == ST_RD1) || (s == ST_RD2) || (s == ST_RD3);
    endfunction

    // True for the states in which a returning read datum is compared
    function automatic logic is_update_state(input state_t s);
        return (s == ST_RD2) || (s == ST_RD3) || (s == ST_ACC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/max_acc.sv
`default_nettype none
// ============================================================================
//  Module   : max_acc
//  Purpose  : Per-channel signed running maximum over one 2x2 window.
//             'init' loads the first datum, 'update' keeps the larger value
//             (strictly greater replaces). Output optionally clamped at zero.
//  Options  : MAXPOOL_RELU_EN - negative maxima are presented as 0.
//  Revision : 1.0  initial release
// ============================================================================
module max_acc
    import maxpool_pkg::*;
#(
    parameter int DATA_W = MP_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init,
    input  logic                     update,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);

    logic signed [DATA_W-1:0] max_q;
    logic signed [DATA_W-1:0] max_d;

    // Next maximum: first datum of a window loads, later ones only if larger
    always_comb begin
        max_d = max_q;
        if (init) begin
            max_d = din;
        end else if (update && (din > max_q)) begin
            max_d = din;
        end
    end

    // Running-maximum register, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

`ifdef MAXPOOL_RELU_EN
    // Rectified output: a negative maximum becomes zero
    assign dout = max_q[DATA_W-1] ? '0 : max_q;
`else
    // Raw signed maximum
    assign dout = max_q;
`endif

endmodule
`default_nettype wire

// File: rtl/maxpool_2x2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_2x2_ctrl
//  Purpose  : 2x2 / stride-2 max-pooling controller for three conv channels.
//             Walks the pooled map in raster order; for each output pixel it
//             reads the four window addresses, keeps three running maxima and
//             writes the results to three channel regions of pooled memory.
//             Six cycles per output pixel.
//  Options  : MAXPOOL_RELU_EN - clamp pooled values below zero to zero.
//  Revision : 1.0  initial release
// ============================================================================
module maxpool_2x2_ctrl
    import maxpool_pkg::*;
#(
    parameter int N_C    = MP_N_C,
    parameter int N_R    = MP_N_R,
    parameter int DATA_W = MP_DATA_W,
    parameter int ADDR_W = MP_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     ren,
    output logic [ADDR_W-1:0]        radd,
    input  logic signed [DATA_W-1:0] rdata1,
    input  logic signed [DATA_W-1:0] rdata2,
    input  logic signed [DATA_W-1:0] rdata3,
    output logic                     wen,
    output logic [ADDR_W-1:0]        wadd1,
    output logic [ADDR_W-1:0]        wadd2,
    output logic [ADDR_W-1:0]        wadd3,
    output logic signed [DATA_W-1:0] data_out1,
    output logic signed [DATA_W-1:0] data_out2,
    output logic signed [DATA_W-1:0] data_out3
);

    // Pooled-map geometry
    localparam int P_COLS = N_C / 2;
    localparam int P_ROWS = N_R / 2;
    localparam int P_TOT  = P_COLS * P_ROWS;

    localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(P_COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(P_TOT - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(2 * N_C);
    localparam logic [ADDR_W-1:0] COL_OFS    = ADDR_W'(N_C);
    localparam logic [ADDR_W-1:0] CH2_BASE   = ADDR_W'(P_TOT);
    localparam logic [ADDR_W-1:0] CH3_BASE   = ADDR_W'(2 * P_TOT);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    // State and pixel counters
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // Registered outputs
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] radd_q, radd_d;
    logic [ADDR_W-1:0] wadd1_q, wadd1_d;
    logic [ADDR_W-1:0] wadd2_q, wadd2_d;
    logic [ADDR_W-1:0] wadd3_q, wadd3_d;

    // Window origin for the pixel the next state works on
    logic [ADDR_W-1:0] a0_d;

    // Accumulator control and per-channel data
    logic                     acc_init;
    logic                     acc_update;
    logic signed [DATA_W-1:0] ch_rdata [3];
    logic signed [DATA_W-1:0] ch_dout  [3];

    // Next state and raster counters; counters advance on leaving WR
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                r_d   = '0;
                c_d   = '0;
                idx_d = '0;
                if (start) begin
                    state_d = ST_RD0;
                end
            end
            ST_RD0:  state_d = ST_RD1;
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = ST_RD3;
            ST_RD3:  state_d = ST_ACC;
            ST_ACC:  state_d = ST_WR;
            ST_WR: begin
                if (idx_q < LAST_IDX) begin
                    state_d = ST_RD0;
                    idx_d   = idx_q + ONE;
                    if (c_q == LAST_COL) begin
                        c_d = '0;
                        r_d = r_q + ONE;
                    end else begin
                        c_d = c_q + ONE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                r_d     = '0;
                c_d     = '0;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the cycle spent in state_d
    always_comb begin
        a0_d    = (r_d * ROW_STRIDE) + (c_d + c_d);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        ren_d   = is_read_state(state_d);
        wen_d   = (state_d == ST_WR);
        radd_d  = radd_q;
        wadd1_d = wadd1_q;
        wadd2_d = wadd2_q;
        wadd3_d = wadd3_q;
        case (state_d)
            ST_RD0:  radd_d = a0_d;
            ST_RD1:  radd_d = a0_d + ONE;
            ST_RD2:  radd_d = a0_d + COL_OFS;
            ST_RD3:  radd_d = a0_d + COL_OFS + ONE;
            default: radd_d = radd_q;
        endcase
        if (state_d == ST_WR) begin
            wadd1_d = idx_d;
            wadd2_d = idx_d + CH2_BASE;
            wadd3_d = idx_d + CH3_BASE;
        end
    end

    // FSM, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            radd_q  <= '0;
            wadd1_q <= '0;
            wadd2_q <= '0;
            wadd3_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            radd_q  <= radd_d;
            wadd1_q <= wadd1_d;
            wadd2_q <= wadd2_d;
            wadd3_q <= wadd3_d;
        end
    end

    // Read data lags the address by one cycle: the RD0 datum arrives in RD1
    // and the RD3 datum in ACC
    assign acc_init   = (state_q == ST_RD1);
    assign acc_update = is_update_state(state_q);

    assign ch_rdata[0] = rdata1;
    assign ch_rdata[1] = rdata2;
    assign ch_rdata[2] = rdata3;

    // One running-maximum unit per channel
    generate
        for (genvar g = 0; g < 3; g++) begin : g_ch
            max_acc #(
                .DATA_W (DATA_W)
            ) u_max_acc (
                .clk    (clk),
                .rst_n  (rst_n),
                .init   (acc_init),
                .update (acc_update),
                .din    (ch_rdata[g]),
                .dout   (ch_dout[g])
            );
        end
    endgenerate

    assign busy      = busy_q;
    assign done      = done_q;
    assign ren       = ren_q;
    assign radd      = radd_q;
    assign wen       = wen_q;
    assign wadd1     = wadd1_q;
    assign wadd2     = wadd2_q;
    assign wadd3     = wadd3_q;
    assign data_out1 = ch_dout[0];
    assign data_out2 = ch_dout[1];
    assign data_out3 = ch_dout[2];

endmodule
`default_nettype wire
